star_scan_ctrl: RTL
===================

Name: star_scan_ctrl

Overview:
Parametrised top-level controller for the star-finding pipeline.
- Raster-scans a frame buffer of any size.
- Compares each pixel against a runtime threshold.
- On a hit, sequences the five helper blocks in order: rows, left, right, draw, clean. Each gets a one-cycle go pulse and returns a done.
- Adds start/done handshake, per-stage timeout, star counting and status outputs.
- Sits between the image RAM (read port) and the mapping, draw and clean blocks.

Parameters:
- IMG_W, 160, image width in pixels
- IMG_H, 120, image height in pixels
- XSZ, 8, x counter width, must hold IMG_W-1
- YSZ, 7, y counter width, must hold IMG_H-1
- ADDR_SZ, 15, RAM address width, must hold IMG_W*IMG_H-1
- COL_SZ, 3, pixel width
- NSTAR_SZ, 8, star counter width
- TO_SZ, 12, stage timeout counter width; timeout = 2^TO_SZ-1 cycles

Ports:
- clk, in, 1, clock
- resetn, in, 1, synchronous active-low reset
- start, in, 1, begin scan; sampled only in IDLE
- threshold, in, COL_SZ, hit when pix_val > threshold (unsigned, strict); sampled at start
- pix_val, in, COL_SZ, RAM read data; 1-cycle synchronous read latency
- rd_addr, out, ADDR_SZ, y_count*IMG_W + x_count
- x_count, out, XSZ, current column
- y_count, out, YSZ, current row
- go_rows, go_left, go_right, go_draw, go_clean, out, 1 each, one-cycle start pulses
- done_rows, done_left, done_right, done_draw, done_clean, in, 1 each, stage completion (pulse or level)
- busy, out, 1, high from the cycle after start is accepted until FINISH completes
- done, out, 1, one-cycle pulse in the FINISH state
- star_count, out, NSTAR_SZ, stars fully processed this frame; saturates at all-ones
- err_timeout, out, 1, sticky; set on any stage timeout; cleared on the next accepted start
- stage_id, out, 3, 0 = scan, 1 = rows, 2 = left, 3 = right, 4 = draw, 5 = clean, 6 = finish

Behaviour:
- Reset: every output and counter is 0, state IDLE. Reset mid-frame aborts immediately; no go pulse or done is issued.
- States: IDLE, READ, CHECK, INCR, ROWS, LEFT, RIGHT, DRAW, CLEAN, FINISH.
- IDLE: start=1 latches threshold, clears x, y, star_count and err_timeout, then goes to READ. start is ignored in every other state.
- READ: rd_addr is valid for the current x,y. Go to CHECK.
- CHECK: pix_val is valid. Hit goes to ROWS; otherwise go to INCR.
- INCR:
  - If x == IMG_W-1 and y == IMG_H-1, go to FINISH.
  - Else if x == IMG_W-1: x=0, y=y+1, go to READ.
  - Else x=x+1, go to READ.
  - A scan-only pixel takes exactly 3 cycles.
- Stage states (ROWS, LEFT, RIGHT, DRAW, CLEAN):
  - The go pulse is asserted on the first cycle in the state only.
  - done is ignored in that same cycle and accepted on any later cycle.
  - Accepted done advances ROWS→LEFT→RIGHT→DRAW→CLEAN. CLEAN done increments star_count (saturating) and goes to INCR.
- Timeout: the counter clears on stage entry and increments each cycle in the stage. On reaching 2^TO_SZ-1 without done: set err_timeout, leave star_count unchanged, skip the remaining stages, go to INCR. A done arriving in the timeout cycle wins over the timeout.
- x/y hold while in stage states. The cleaned pixel is not re-read; the scan resumes at the next pixel.
- FINISH: done=1 for one cycle, busy=0 on the following cycle, go to IDLE.
- A start asserted in the same cycle as done is ignored. start is accepted from the next IDLE cycle.
- All go outputs are registered-free decodes of state plus a first-cycle flag; no glitching between stages.

Decomposition:
- Package star_pkg: state encoding, stage_id constants, the go/done index order.
- One sub-module, scan_counter: x/y counters with wrap, last-pixel flag, and the address multiply-add (IMG_W constant).
- The FSM, timeout counter and star counter live in star_scan_ctrl.

Test Plan:
All scenarios use IMG_W=4, IMG_H=3, TO_SZ=4 unless noted.
1. All-zero image, threshold 0, start at cycle T → no go pulses; done at T+37; star_count 0; rd_addr sequence 0..11.
2. Single pixel value 5 at (2,1), threshold 3, each stage's done returned 2 cycles after its go → go pulses in order rows, left, right, draw, clean, each exactly 1 cycle wide; star_count 1; scan resumes at address 7.
3. Same pixel, threshold 5 → no hit (strict compare); done at T+37.
4. done_left never asserted → err_timeout set 15 cycles after go_left; no go_right; star_count 0; scan completes and done pulses; the next start clears err_timeout.
5. Reset asserted during DRAW → next cycle: all outputs 0, state IDLE; a subsequent start scans from address 0.
6. start held high continuously across done → exactly one frame per IDLE entry; second frame begins the cycle after returning to IDLE; start pulses while busy have no effect.

Source files
------------

// File: rtl/star_pkg.sv
// rtl/star_pkg.sv - state encoding, stage ids and go/done index order for the star scan controller
package star_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_READ,
        ST_CHECK,
        ST_INCR,
        ST_ROWS,
        ST_LEFT,
        ST_RIGHT,
        ST_DRAW,
        ST_CLEAN,
        ST_FINISH
    } state_t;

    localparam logic [2:0] SID_SCAN   = 3'd0;
    localparam logic [2:0] SID_ROWS   = 3'd1;
    localparam logic [2:0] SID_LEFT   = 3'd2;
    localparam logic [2:0] SID_RIGHT  = 3'd3;
    localparam logic [2:0] SID_DRAW   = 3'd4;
    localparam logic [2:0] SID_CLEAN  = 3'd5;
    localparam logic [2:0] SID_FINISH = 3'd6;

    localparam int NSTAGE    = 5;
    localparam int IDX_ROWS  = 0;
    localparam int IDX_LEFT  = 1;
    localparam int IDX_RIGHT = 2;
    localparam int IDX_DRAW  = 3;
    localparam int IDX_CLEAN = 4;

    function automatic state_t next_stage(input state_t s);
        case (s)
            ST_ROWS:  next_stage = ST_LEFT;
            ST_LEFT:  next_stage = ST_RIGHT;
            ST_RIGHT: next_stage = ST_DRAW;
            ST_DRAW:  next_stage = ST_CLEAN;
            default:  next_stage = ST_INCR;
        endcase
    endfunction

    function automatic logic [2:0] stage_id_of(input state_t s);
        case (s)
            ST_ROWS:   stage_id_of = SID_ROWS;
            ST_LEFT:   stage_id_of = SID_LEFT;
            ST_RIGHT:  stage_id_of = SID_RIGHT;
            ST_DRAW:   stage_id_of = SID_DRAW;
            ST_CLEAN:  stage_id_of = SID_CLEAN;
            ST_FINISH: stage_id_of = SID_FINISH;
            default:   stage_id_of = SID_SCAN;
        endcase
    endfunction

endpackage

// File: rtl/scan_counter.sv
// rtl/scan_counter.sv - raster x/y counters with last-pixel flag and frame buffer address
module scan_counter #(
    parameter int IMG_W   = 160,
    parameter int IMG_H   = 120,
    parameter int XSZ     = 8,
    parameter int YSZ     = 7,
    parameter int ADDR_SZ = 15
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clr,
    input  logic               adv,
    output logic [XSZ-1:0]     x_count,
    output logic [YSZ-1:0]     y_count,
    output logic               lastPix,
    output logic [ADDR_SZ-1:0] rd_addr
);

    localparam logic [XSZ-1:0] X_LAST = XSZ'(IMG_W - 1);
    localparam logic [YSZ-1:0] Y_LAST = YSZ'(IMG_H - 1);

    logic xLast;

    assign xLast   = (x_count == X_LAST);
    assign lastPix = xLast && (y_count == Y_LAST);
    assign rd_addr = ADDR_SZ'(y_count) * ADDR_SZ'(IMG_W) + ADDR_SZ'(x_count);

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            x_count <= '0;
            y_count <= '0;
        end else if (adv) begin
            if (xLast) begin
                x_count <= '0;
                y_count <= y_count + YSZ'(1);
            end else begin
                x_count <= x_count + XSZ'(1);
            end
        end
    end

endmodule

// File: rtl/star_scan_ctrl.sv
// rtl/star_scan_ctrl.sv - raster scan of the frame buffer, sequencing the five star helper stages per hit
module star_scan_ctrl
    import star_pkg::*;
#(
    parameter int IMG_W    = 160,
    parameter int IMG_H    = 120,
    parameter int XSZ      = 8,
    parameter int YSZ      = 7,
    parameter int ADDR_SZ  = 15,
    parameter int COL_SZ   = 3,
    parameter int NSTAR_SZ = 8,
    parameter int TO_SZ    = 12
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [COL_SZ-1:0]   threshold,
    input  logic [COL_SZ-1:0]   pix_val,
    output logic [ADDR_SZ-1:0]  rd_addr,
    output logic [XSZ-1:0]      x_count,
    output logic [YSZ-1:0]      y_count,
    output logic                go_rows,
    output logic                go_left,
    output logic                go_right,
    output logic                go_draw,
    output logic                go_clean,
    input  logic                done_rows,
    input  logic                done_left,
    input  logic                done_right,
    input  logic                done_draw,
    input  logic                done_clean,
    output logic                busy,
    output logic                done,
    output logic [NSTAR_SZ-1:0] star_count,
    output logic                err_timeout,
    output logic [2:0]          stage_id
);

    // Counter value during the last cycle a stage may stay; it would reach all-ones on the next edge.
    localparam logic [TO_SZ-1:0] TO_LAST = {{(TO_SZ-1){1'b1}}, 1'b0};

    state_t              state;
    logic                firstCycle;
    logic [COL_SZ-1:0]   thr;
    logic [TO_SZ-1:0]    toCount;
    logic                lastPix;
    logic                cntClr;
    logic                cntAdv;
    logic [NSTAGE-1:0]   stageHot;
    logic [NSTAGE-1:0]   doneVec;
    logic [NSTAGE-1:0]   goVec;
    logic                acceptDone;
    logic                toHit;

    assign cntClr = (state == ST_IDLE) && start;
    assign cntAdv = (state == ST_INCR) && !lastPix;

    scan_counter #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .XSZ     (XSZ),
        .YSZ     (YSZ),
        .ADDR_SZ (ADDR_SZ)
    ) u_scan (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (cntClr),
        .adv     (cntAdv),
        .x_count (x_count),
        .y_count (y_count),
        .lastPix (lastPix),
        .rd_addr (rd_addr)
    );

    always_comb begin
        stageHot = '0;
        case (state)
            ST_ROWS:  stageHot[IDX_ROWS]  = 1'b1;
            ST_LEFT:  stageHot[IDX_LEFT]  = 1'b1;
            ST_RIGHT: stageHot[IDX_RIGHT] = 1'b1;
            ST_DRAW:  stageHot[IDX_DRAW]  = 1'b1;
            ST_CLEAN: stageHot[IDX_CLEAN] = 1'b1;
            default:  stageHot = '0;
        endcase
    end

    always_comb begin
        doneVec            = '0;
        doneVec[IDX_ROWS]  = done_rows;
        doneVec[IDX_LEFT]  = done_left;
        doneVec[IDX_RIGHT] = done_right;
        doneVec[IDX_DRAW]  = done_draw;
        doneVec[IDX_CLEAN] = done_clean;
    end

    // A done seen in the go cycle belongs to a previous request and is dropped.
    assign goVec      = firstCycle ? stageHot : '0;
    assign acceptDone = !firstCycle && |(stageHot & doneVec);
    assign toHit      = (toCount == TO_LAST);

    assign go_rows  = goVec[IDX_ROWS];
    assign go_left  = goVec[IDX_LEFT];
    assign go_right = goVec[IDX_RIGHT];
    assign go_draw  = goVec[IDX_DRAW];
    assign go_clean = goVec[IDX_CLEAN];
    assign stage_id = stage_id_of(state);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            firstCycle  <= 1'b0;
            thr         <= '0;
            toCount     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            star_count  <= '0;
            err_timeout <= 1'b0;
        end else begin
            done       <= 1'b0;
            firstCycle <= 1'b0;
            toCount    <= toCount + TO_SZ'(1);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        thr         <= threshold;
                        star_count  <= '0;
                        err_timeout <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_READ;
                    end
                end
                ST_READ: state <= ST_CHECK;
                ST_CHECK: begin
                    if (pix_val > thr) begin
                        state      <= ST_ROWS;
                        firstCycle <= 1'b1;
                        toCount    <= '0;
                    end else begin
                        state <= ST_INCR;
                    end
                end
                ST_INCR: begin
                    if (lastPix) begin
                        state <= ST_FINISH;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_READ;
                    end
                end
                ST_ROWS, ST_LEFT, ST_RIGHT, ST_DRAW, ST_CLEAN: begin
                    if (acceptDone) begin
                        if (state == ST_CLEAN) begin
                            if (star_count != '1) begin
                                star_count <= star_count + NSTAR_SZ'(1);
                            end
                            state <= ST_INCR;
                        end else begin
                            state      <= next_stage(state);
                            firstCycle <= 1'b1;
                            toCount    <= '0;
                        end
                    end else if (toHit) begin
                        err_timeout <= 1'b1;
                        state       <= ST_INCR;
                    end
                end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
